// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered MIPS ALU control decoder with an iterative shift-add multiplier
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Function,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [3:0]       ALUControl,
  output logic             OutValid,
  output logic             IsMul,
  output logic [WIDTH-1:0] MulResult,
  output logic             Stall
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0] cnt;
  logic [3:0] dec;
  logic is_mul_op, accept;
  assign is_mul_op = OpCode == 6'b011100;
  assign accept = state != MUL_RUN && InValid && !Flush;
  assign Stall = state == MUL_RUN || (accept && is_mul_op);
  assign acc_next = acc + mcand * WIDTH'(mplier[BITS_PER_CYCLE-1:0]);
  always_comb begin
    dec = 4'd0;
    if (OpCode == 6'b000000)
      case (Function)
        6'b000000: dec = 4'd6;
        6'b000010: dec = 4'd7;
        6'b101010: dec = 4'd9;
        6'b100101: dec = 4'd3;
        6'b100111: dec = 4'd4;
        6'b100110: dec = 4'd5;
        6'b100010: dec = 4'd1;
        6'b100100: dec = 4'd2;
        default:   dec = 4'd0;
      endcase
    else
      case (OpCode)
        6'b011100: dec = 4'd8;
        6'b001100: dec = 4'd2;
        6'b001101: dec = 4'd3;
        6'b001110: dec = 4'd5;
        6'b001010: dec = 4'd9;
        default:   dec = 4'd0;
      endcase
  end
  always_ff @(posedge Clk) begin
    OutValid <= 1'b0;
    IsMul <= 1'b0;
    if (Reset) begin
      state <= IDLE;
      ALUControl <= '0;
      MulResult <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL_RUN) begin
      if (Flush)
        state <= IDLE;
      else begin
        acc <= acc_next;
        mcand <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= MUL_DONE;
          OutValid <= 1'b1;
          IsMul <= 1'b1;
          MulResult <= acc_next;
        end
      end
    end else begin
      state <= IDLE;
      if (accept) begin
        ALUControl <= dec;
        if (is_mul_op) begin
          state <= MUL_RUN;
          mcand <= A;
          mplier <= B;
          acc <= '0;
          cnt <= CW'(N);
        end else
          OutValid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq at BITS_PER_CYCLE 1 and 4
module tb_alu_ctrl_seq;
  localparam int W = 32;
  localparam logic [5:0] MUL = 6'b011100;
  typedef struct {int cyc; bit dut; logic [3:0] ctrl; bit is_mul; logic [W-1:0] res;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, sel = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic [5:0] op = '0, fn = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] ctrl1, ctrl4;
  logic ov1, ov4, im1, im4, st1, st4;
  logic [W-1:0] mr1, mr4;
  exp_t q[$];
  int cyc = 0, free_cyc = 0, nvec = 0, nerr = 0;
  logic [5:0] opc[11] = '{6'b001100, 6'b001000, 6'b100011, 6'b101011, 6'b101000, 6'b100001,
                          6'b100000, 6'b101001, 6'b001101, 6'b001110, 6'b001010};
  logic [5:0] fnc[9] = '{6'b000000, 6'b000010, 6'b101010, 6'b100101, 6'b100111, 6'b100110,
                         6'b100000, 6'b100010, 6'b100100};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_ctrl_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .Clk(clk), .Reset(rst), .InValid(in_valid & ~sel), .OpCode(op), .Function(fn), .A(a), .B(b),
    .Flush(flush & ~sel), .ALUControl(ctrl1), .OutValid(ov1), .IsMul(im1), .MulResult(mr1), .Stall(st1)
  );
  alu_ctrl_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .Clk(clk), .Reset(rst), .InValid(in_valid & sel), .OpCode(op), .Function(fn), .A(a), .B(b),
    .Flush(flush & sel), .ALUControl(ctrl4), .OutValid(ov4), .IsMul(im4), .MulResult(mr4), .Stall(st4)
  );
  function automatic logic [3:0] dec(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000)
      case (f)
        6'b000000: return 4'd6;
        6'b000010: return 4'd7;
        6'b101010: return 4'd9;
        6'b100101: return 4'd3;
        6'b100111: return 4'd4;
        6'b100110: return 4'd5;
        6'b100010: return 4'd1;
        6'b100100: return 4'd2;
        default:   return 4'd0;
      endcase
    case (o)
      MUL:       return 4'd8;
      6'b001100: return 4'd2;
      6'b001101: return 4'd3;
      6'b001110: return 4'd5;
      6'b001010: return 4'd9;
      default:   return 4'd0;
    endcase
  endfunction
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ov1 || ov4) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_outvalid cyc %0d: got OutValid=1 expected no pending op", cyc);
      end else begin
        e = q.pop_front();
        check("out_dut", ov4, e.dut);
        check("out_cycle", cyc, e.cyc);
        check("out_ctrl", e.dut ? ctrl4 : ctrl1, e.ctrl);
        check("out_ismul", e.dut ? im4 : im1, e.is_mul);
        if (e.is_mul) check("mul_result", e.dut ? mr4 : mr1, e.res);
      end
    end
  end
  task automatic step(input bit v, input logic [5:0] o, input logic [5:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y, input bit fl);
    int n = sel ? W / 4 : W;
    bit busy = cyc < free_cyc;
    bit acc = !busy && v && !fl;
    bit mul = o == MUL;
    in_valid = v; op = o; fn = f; a = x; b = y; flush = fl;
    if (acc && mul) begin
      q.push_back('{cyc + n + 1, sel, 4'd8, 1'b1, x * y});
      free_cyc = cyc + n + 1;
    end else if (acc)
      q.push_back('{cyc + 1, sel, dec(o, f), 1'b0, '0});
    if (busy && fl) begin
      void'(q.pop_back());
      free_cyc = cyc + 1;
    end
    @(negedge clk);
    check("stall", sel ? st4 : st1, busy || (acc && mul));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int k);
    repeat (k) step(1'b0, '0, '0, '0, '0, 1'b0);
  endtask
  task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    step(1'b1, MUL, '0, x, y, 1'b0);
    while (cyc < free_cyc) step(1'($urandom), 6'($urandom), 6'($urandom), $urandom, $urandom, 1'b0);
  endtask
  task automatic drain;
    while (cyc < free_cyc) idle(1);
    idle(2);
  endtask
  task automatic rand_step;
    int r = $urandom_range(0, 15);
    logic [5:0] o = r < 5 ? 6'd0 : r < 8 ? MUL : r < 13 ? opc[$urandom_range(0, 10)] : 6'($urandom);
    logic [5:0] f = $urandom_range(0, 3) == 0 ? 6'($urandom) : fnc[$urandom_range(0, 8)];
    step($urandom_range(0, 3) != 0, o, f, $urandom, $urandom, $urandom_range(0, 19) == 0);
  endtask
  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    free_cyc = 0;
    @(negedge clk);
    check("rst_ctrl", sel ? ctrl4 : ctrl1, '0);
    check("rst_outvalid", sel ? ov4 : ov1, '0);
    check("rst_ismul", sel ? im4 : im1, '0);
    check("rst_mulresult", sel ? mr4 : mr1, '0);
    check("rst_stall", sel ? st4 : st1, '0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset;
    step(1'b1, 6'b000000, 6'b100000, '0, '0, 1'b0);
    step(1'b1, 6'b000000, 6'b100010, '0, '0, 1'b0);
    step(1'b1, 6'b000000, 6'b100111, '0, '0, 1'b0);
    step(1'b1, 6'b001101, 6'b000000, '0, '0, 1'b0);
    step(1'b1, 6'b001010, 6'b000000, '0, '0, 1'b0);
    idle(2);
    run_mul(32'd7, 32'd6);
    idle(1);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mul(32'h80000000, 32'd2);
    run_mul(32'd3, 32'd5);
    idle(2);
    step(1'b1, 6'b111111, 6'b000000, '0, '0, 1'b0);
    step(1'b1, 6'b000000, 6'b111111, '0, '0, 1'b0);
    step(1'b1, 6'b000000, 6'b000000, '0, '0, 1'b0);
    step(1'b1, 6'b000000, 6'b100110, '0, '0, 1'b1);
    idle(2);
    run_mul(32'd7, 32'd6);
    idle(1);
    step(1'b1, MUL, '0, 32'd9, 32'd9, 1'b0);
    idle(9);
    step(1'b0, '0, '0, '0, '0, 1'b1);
    idle(3);
    check("flush_hold", mr1, 32'd42);
    step(1'b1, MUL, '0, 32'd5, 32'd5, 1'b0);
    idle(4);
    do_reset;
    repeat (400) rand_step;
    drain;
    sel = 1'b1;
    do_reset;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mul(32'h80000000, 32'd2);
    run_mul(32'd7, 32'd6);
    idle(1);
    repeat (300) rand_step;
    drain;
    check("queue_empty", W'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
